// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel frame controller: FSM encoding
// and the default word width.
package sipo_pkg;
    localparam int WORD_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;
endpackage

// File: rtl/sipo_frame_ctrl_sync.sv
// Input synchroniser for the serial link: sclk chain with a registered
// sample-edge pulse, plus a parallel chain for the level/data inputs.
module sync_edge_det #(
    parameter int          STAGES      = 2,
    parameter int          W           = 2,
    parameter logic [W-1:0] RST_VAL    = '0,
    parameter bit          SAMPLE_EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk_i,
    input  logic [W-1:0] d_i,
    output logic         edge_o,
    output logic [W-1:0] q_o
);
    logic [STAGES-1:0]       sclk_q;
    logic                    sclk_dly_q;
    logic                    edge_q;
    // One stage longer than the sclk chain so data lines up with the registered edge.
    logic [STAGES:0][W-1:0]  d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q     <= '0;
            sclk_dly_q <= 1'b0;
            edge_q     <= 1'b0;
            d_q        <= {(STAGES+1){RST_VAL}};
        end else begin
            sclk_q     <= {sclk_q[STAGES-2:0], sclk_i};
            sclk_dly_q <= sclk_q[STAGES-1];
            edge_q     <= SAMPLE_EDGE ? (sclk_dly_q & ~sclk_q[STAGES-1])
                                      : (~sclk_dly_q & sclk_q[STAGES-1]);
            d_q        <= {d_q[STAGES-1:0], d_i};
        end
    end

    assign edge_o = edge_q;
    assign q_o    = d_q[STAGES];
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Front-end controller for a WORD_W-bit SIPO: synchronises sclk/sdata/cs_n,
// issues shift pulses, counts bits and runs the word_valid/word_ready handshake.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter  int WORD_W      = WORD_W_DEF,
    parameter  int SYNC_STAGES = 2,
    parameter  int SAMPLE_EDGE = 0,
    localparam int CW          = $clog2(WORD_W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk_in,
    input  logic          sdata_in,
    input  logic          cs_n_in,
    output logic          shift_en,
    output logic          shift_bit,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          overrun,
    output logic          frame_err,
    output logic [CW-1:0] bit_cnt
);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);

    logic          edge_s, sdata_s, cs_n_s, hs;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          shift_en_q, shift_en_d, shift_bit_q, shift_bit_d;
    logic          valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;

    sync_edge_det #(
        .STAGES     (SYNC_STAGES),
        .W          (2),
        .RST_VAL    (2'b10),
        .SAMPLE_EDGE(SAMPLE_EDGE != 0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk_i(sclk_in),
        .d_i   ({cs_n_in, sdata_in}),
        .edge_o(edge_s),
        .q_o   ({cs_n_s, sdata_s})
    );

    assign hs = valid_q & word_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_en_d  = 1'b0;
        shift_bit_d = 1'b0;
        valid_d     = valid_q;
        ovr_d       = 1'b0;
        ferr_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!cs_n_s) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_n_s) begin
                    ferr_d  = (cnt_q != '0);
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (edge_s) begin
                    shift_en_d  = 1'b1;
                    shift_bit_d = sdata_s;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CNT_FULL - 1'b1) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hs) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = cs_n_s ? ST_IDLE : ST_SHIFT;
                    // The consumer takes q this cycle, so a coinciding edge can still shift.
                    if (edge_s && !cs_n_s) begin
                        shift_en_d  = 1'b1;
                        shift_bit_d = sdata_s;
                        cnt_d       = CW'(1);
                        if (WORD_W == 1) state_d = ST_HOLD;
                    end
                end else begin
                    valid_d = 1'b1;
                    ovr_d   = edge_s;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_en_q  <= 1'b0;
            shift_bit_q <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_en_q  <= shift_en_d;
            shift_bit_q <= shift_bit_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign shift_bit  = shift_bit_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;
    assign bit_cnt    = cnt_q;
endmodule
